ps2_arrow_sequencer: RTL
========================

# ps2_arrow_sequencer

Scan-code sequencer that sits after the PS/2 frame receiver and turns its validated byte stream into key make/break events. It tracks the 0xE0 extended prefix and the 0xF0 break prefix, and recovers from dropped or malformed sequences. It keeps level "held" state for the left and right arrow keys. It replaces the receiver's sticky arrow outputs with correct press/release behaviour for the game logic.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1_000_000: maximum number of clk cycles allowed between a prefix byte and the byte that completes it.
- REQUIRE_EXT, 0: when 1, arrow codes match only if preceded by 0xE0; when 0, arrow codes match regardless of prefix.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- code_valid  in  1  one-cycle strobe; code_byte is valid.
- code_byte  in  8  received scan-code byte.
- code_error  in  1  one-cycle strobe; the receiver rejected a frame (start, stop or parity error).
- key_event_valid  out  1  one-cycle strobe for every completed make or break.
- key_event_code  out  8  key code of the event, with prefixes stripped.
- key_event_break  out  1  1 = release, 0 = press.
- key_event_ext  out  1  1 = the sequence carried 0xE0.
- left_held  out  1  level; left arrow is currently down.
- right_held  out  1  level; right arrow is currently down.
- left_press, right_press  out  1  one-cycle strobe on the 0→1 transition of the matching held flag.
- left_release, right_release  out  1  one-cycle strobe on the 1→0 transition of the matching held flag.
- protocol_error  out  1  one-cycle strobe; a sequence was discarded.

## Operation
FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0.
- IDLE:
  - 0xE0 → GOT_E0.
  - 0xF0 → GOT_F0.
  - 0xAA (keyboard self-test pass) → clear both held flags. No release strobes and no event are produced. Stay in IDLE.
  - Any other byte → make event with ext=0. Stay in IDLE.
- GOT_E0:
  - 0xF0 → GOT_E0F0.
  - 0xE0 → ignored; stay in GOT_E0.
  - Any other byte → make event with ext=1, then IDLE.
- GOT_F0:
  - 0xE0 or 0xF0 → protocol_error, then IDLE.
  - Any other byte → break event with ext=0, then IDLE.
- GOT_E0F0:
  - 0xE0 or 0xF0 → protocol_error, then IDLE.
  - Any other byte → break event with ext=1, then IDLE.
- code_error in any state: discard any partial sequence, pulse protocol_error, go to IDLE. Held flags are unchanged.
- Timeout: in any state other than IDLE, a cycle counter runs and is cleared on every code_valid. When it reaches TIMEOUT_CYCLES-1 the FSM goes to IDLE and pulses protocol_error.
- Arrow match: a code of 0x6B is left and 0x74 is right, gated by REQUIRE_EXT.
  - A matching make sets the held flag.
  - A matching break clears the held flag.
- Typematic repeats: each repeated make produces key_event_valid. A press strobe is produced only on the first make.
- A break for a key that is not held produces a key event only; there is no release strobe.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and does not wrap.

## Timing
- All outputs are registered.
- Reset values: every output is 0, key_event_code is 0x00, state is IDLE, the timeout counter is 0.
- Latency: the event, held and strobe outputs update on the first clk edge after the code_valid cycle of the completing byte. This is 1-cycle latency.
- Prefix bytes produce no outputs.
- code_valid and code_error in the same cycle: code_error wins and the byte is dropped.
- code_valid in the same cycle the timeout would fire: the byte wins. It is processed in the current state and the counter clears.
- The block assumes code_valid strobes are at least 1 cycle apart. It accepts back-to-back strobes with no stall; there is no backpressure.
- key_event_* fields are meaningful only while key_event_valid=1 and hold their last value otherwise.
- Reset asserted mid-sequence: state, counter and held flags clear immediately. No release strobes are produced.

## Structure
- Shared package ps2_pkg contains:
  - constants PS2_EXT=8'hE0, PS2_BREAK=8'hF0, PS2_BAT_OK=8'hAA, PS2_KEY_LEFT=8'h6B, PS2_KEY_RIGHT=8'h74;
  - typedef enum ps2_seq_state_t {IDLE, GOT_E0, GOT_F0, GOT_E0F0}.
- One sub-module, ps2_timeout_timer: a clear/enable saturating counter with a terminal-count strobe, parameterised by TIMEOUT_CYCLES.
- The FSM and arrow tracking stay in the top module.

## Test plan
- E0, 6B → key_event_valid with code=6B, ext=1, break=0; left_press strobe; left_held=1.
- Hold left, then E0, F0, 6B → event with break=1, ext=1; left_release strobe; left_held=0.
- E0 74 sent three times → three key_event_valid strobes, one right_press, right_held=1 throughout.
- F0, E0 → protocol_error, state IDLE. Then 74 with REQUIRE_EXT=0 → make with ext=0 and right_held=1. Repeat with REQUIRE_EXT=1 → right_held stays 0.
- E0, then idle for TIMEOUT_CYCLES=16 cycles → protocol_error at cycle 16. The next 6B gives ext=0. Also check code_error during GOT_F0 → protocol_error, held flags unchanged.
- Both arrows held, then AA → both held flags 0 with no strobes. Repeat the setup, assert rst between E0 and F0 → all outputs 0; the next 6B is treated as a make.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants and sequencer state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
  localparam logic [7:0] PS2_KEY_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_KEY_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } ps2_seq_state_t;

endpackage

// File: rtl/ps2_timeout_timer.sv
// Saturating cycle counter with synchronous clear and a terminal-count strobe.
// tc is combinational so the owner can act on it in the same cycle; it is
// suppressed while clr is high so a clearing event always wins over expiry.
module ps2_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] TC_VAL  = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] count;

  // Count enabled cycles, clear on request, hold at all-ones rather than wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = en && !clr && (count == TC_VAL);

endmodule

// File: rtl/ps2_arrow_sequencer.sv
// Turns validated PS/2 scan-code bytes into make/break events, tracks the
// E0/F0 prefixes, and keeps level "held" state for the left/right arrows.
//
// Handshake: code_valid and code_error are single-cycle strobes with no
// backpressure; every byte presented with code_valid is consumed that cycle.
// Outputs are registered and appear one clk edge after the completing byte.
module ps2_arrow_sequencer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter bit REQUIRE_EXT    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       code_valid,
  input  logic [7:0] code_byte,
  input  logic       code_error,
  output logic       key_event_valid,
  output logic [7:0] key_event_code,
  output logic       key_event_break,
  output logic       key_event_ext,
  output logic       left_held,
  output logic       right_held,
  output logic       left_press,
  output logic       right_press,
  output logic       left_release,
  output logic       right_release,
  output logic       protocol_error,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] ST_IDLE     = 2'(IDLE);
  localparam logic [1:0] ST_GOT_E0   = 2'(GOT_E0);
  localparam logic [1:0] ST_GOT_F0   = 2'(GOT_F0);
  localparam logic [1:0] ST_GOT_E0F0 = 2'(GOT_E0F0);

  logic [1:0] state;
  logic [1:0] nxt_state;
  logic       tmo_tc;
  logic       tmo_clr;
  logic       tmo_en;

  logic       ev_fire;
  logic       ev_break;
  logic       ev_ext;
  logic       perr;
  logic       bat_clear;
  logic       is_prefix;
  logic       is_left;
  logic       is_right;

  assign state_dbg = state;

  // The timer only runs while a prefix is pending; any byte or error restarts it
  assign tmo_en  = (state != ST_IDLE);
  assign tmo_clr = code_valid || code_error || (state == ST_IDLE);

  ps2_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (tmo_clr),
    .en  (tmo_en),
    .tc  (tmo_tc)
  );

  assign is_prefix = (code_byte == PS2_EXT) || (code_byte == PS2_BREAK);

  // Decode the incoming byte against the current prefix state
  always_comb begin
    nxt_state = state;
    ev_fire   = 1'b0;
    ev_break  = 1'b0;
    ev_ext    = 1'b0;
    perr      = 1'b0;
    bat_clear = 1'b0;
    if (code_error) begin
      nxt_state = ST_IDLE;
      perr      = 1'b1;
    end else if (code_valid) begin
      case (state)
        ST_IDLE: begin
          if (code_byte == PS2_EXT) begin
            nxt_state = ST_GOT_E0;
          end else if (code_byte == PS2_BREAK) begin
            nxt_state = ST_GOT_F0;
          end else if (code_byte == PS2_BAT_OK) begin
            bat_clear = 1'b1;
          end else begin
            ev_fire = 1'b1;
          end
        end
        ST_GOT_E0: begin
          if (code_byte == PS2_BREAK) begin
            nxt_state = ST_GOT_E0F0;
          end else if (code_byte != PS2_EXT) begin
            ev_fire   = 1'b1;
            ev_ext    = 1'b1;
            nxt_state = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          nxt_state = ST_IDLE;
          if (is_prefix) begin
            perr = 1'b1;
          end else begin
            ev_fire  = 1'b1;
            ev_break = 1'b1;
          end
        end
        default: begin
          nxt_state = ST_IDLE;
          if (is_prefix) begin
            perr = 1'b1;
          end else begin
            ev_fire  = 1'b1;
            ev_break = 1'b1;
            ev_ext   = 1'b1;
          end
        end
      endcase
    end else if (tmo_tc) begin
      nxt_state = ST_IDLE;
      perr      = 1'b1;
    end
  end

  assign is_left  = ev_fire && (code_byte == PS2_KEY_LEFT)  && (!REQUIRE_EXT || ev_ext);
  assign is_right = ev_fire && (code_byte == PS2_KEY_RIGHT) && (!REQUIRE_EXT || ev_ext);

  // State, event fields and single-cycle strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      key_event_valid <= 1'b0;
      key_event_code  <= 8'h00;
      key_event_break <= 1'b0;
      key_event_ext   <= 1'b0;
      protocol_error  <= 1'b0;
    end else begin
      state           <= nxt_state;
      key_event_valid <= ev_fire;
      protocol_error  <= perr;
      if (ev_fire) begin
        key_event_code  <= code_byte;
        key_event_break <= ev_break;
        key_event_ext   <= ev_ext;
      end
    end
  end

  // Arrow held levels with edge strobes; self-test pass clears silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_held     <= 1'b0;
      right_held    <= 1'b0;
      left_press    <= 1'b0;
      right_press   <= 1'b0;
      left_release  <= 1'b0;
      right_release <= 1'b0;
    end else begin
      left_press    <= 1'b0;
      right_press   <= 1'b0;
      left_release  <= 1'b0;
      right_release <= 1'b0;
      if (bat_clear) begin
        left_held  <= 1'b0;
        right_held <= 1'b0;
      end
      if (is_left) begin
        if (ev_break) begin
          left_held    <= 1'b0;
          left_release <= left_held;
        end else begin
          left_held  <= 1'b1;
          left_press <= !left_held;
        end
      end
      if (is_right) begin
        if (ev_break) begin
          right_held    <= 1'b0;
          right_release <= right_held;
        end else begin
          right_held  <= 1'b1;
          right_press <= !right_held;
        end
      end
    end
  end

endmodule
